exec_unit: RTL and testbench

- Execute stage directly downstream of the 16-entry register file.
- Consumes the two read operands (rd1 -> a, rd2 -> b) and a decoded op and destination index. Produces the write-back triple (wr_en, wr_addr, wr_data), which drives the register file's write, rd and data inputs.
- Logic/arithmetic ops complete in one cycle. Multiplies run as a multi-cycle shift-add sequence under a busy/done handshake.

---
 rtl/exec_unit.sv | 190 +++++++++++++++++++
 tb/tb_exec_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/exec_unit.sv
// exec_unit: execute stage fed by the register file read ports.
// Ports: clk/rst, start/op/dst/a/b request in; busy/done/wr_en/wr_addr/wr_data/zero/carry out.
module exec_unit #(
    parameter int WIDTH = 32,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [AW-1:0]    dst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             wr_en,
    output logic [AW-1:0]    wr_addr,
    output logic [WIDTH-1:0] wr_data,
    output logic             zero,
    output logic             carry
);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_NOR   = 4'd5;
    localparam logic [3:0] OP_SLT   = 4'd6;
    localparam logic [3:0] OP_SLTU  = 4'd7;
    localparam logic [3:0] OP_SLL   = 4'd8;
    localparam logic [3:0] OP_SRL   = 4'd9;
    localparam logic [3:0] OP_SRA   = 4'd10;
    localparam logic [3:0] OP_MULLO = 4'd11;
    localparam logic [3:0] OP_MULHU = 4'd12;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_WB
    } state_t;

    state_t             state_q;
    logic               busy_q;
    logic               done_q;
    logic               wr_en_q;
    logic [AW-1:0]      wr_addr_q;
    logic [WIDTH-1:0]   wr_data_q;
    logic               zero_q;
    logic               carry_q;

    // Multiply datapath: multiplicand shifts left, multiplier shifts right.
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;
    logic               mul_hi_q;
    logic [AW-1:0]      dst_q;
    logic               mul_last;
    logic [WIDTH-1:0]   mul_res;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [4:0]         shamt;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_cout;
    logic               is_mul;
    logic               is_rsv;

    assign busy    = busy_q;
    assign done    = done_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign zero    = zero_q;
    assign carry   = carry_q;

    // Single-cycle result computed straight from the ports; it is
    // captured on the accepting edge, so the ports may change afterwards.
    always_comb begin
        sum      = {1'b0, a} + {1'b0, b};
        // Bit WIDTH of the extended difference is the unsigned borrow.
        diff     = {1'b0, a} - {1'b0, b};
        shamt    = b[4:0];
        alu_res  = '0;
        alu_cout = 1'b0;
        is_mul   = 1'b0;
        is_rsv   = 1'b0;
        unique case (op)
            OP_ADD: begin
                alu_res  = sum[WIDTH-1:0];
                alu_cout = sum[WIDTH];
            end
            OP_SUB: begin
                alu_res  = diff[WIDTH-1:0];
                alu_cout = diff[WIDTH];
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOR:  alu_res = ~(a | b);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
            OP_MULLO, OP_MULHU: is_mul = 1'b1;
            default: is_rsv = 1'b1;
        endcase
    end

    always_comb begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mul_last = (cnt_q == CW'(WIDTH - 1));
        mul_res  = mul_hi_q ? acc_d[2*WIDTH-1:WIDTH] : acc_d[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            mul_hi_q  <= 1'b0;
            dst_q     <= '0;
        end else begin
            done_q  <= 1'b0;
            wr_en_q <= 1'b0;
            unique case (state_q)
                S_MUL: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (mul_last) begin
                        state_q   <= S_WB;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= dst_q;
                        wr_data_q <= mul_res;
                        zero_q    <= (mul_res == '0);
                        carry_q   <= 1'b0;
                    end
                end
                S_IDLE, S_WB: begin
                    if (start && is_mul) begin
                        state_q  <= S_MUL;
                        busy_q   <= 1'b1;
                        acc_q    <= '0;
                        mcand_q  <= {{WIDTH{1'b0}}, a};
                        mplier_q <= b;
                        cnt_q    <= '0;
                        mul_hi_q <= (op == OP_MULHU);
                        dst_q    <= dst;
                    end else if (start) begin
                        // Reserved ops still pulse done but never write.
                        state_q   <= S_WB;
                        done_q    <= 1'b1;
                        wr_en_q   <= ~is_rsv;
                        if (!is_rsv) begin
                            wr_addr_q <= dst;
                        end
                        wr_data_q <= alu_res;
                        zero_q    <= (alu_res == '0);
                        carry_q   <= alu_cout;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: directed vector table plus multiply/handshake/reset sequences.
// Drives the exec_unit request ports and checks the write-back outputs.
module tb_exec_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [3:0]  dst = 4'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic        done;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        zero;
    logic        carry;

    int total = 0;
    int passed = 0;

    exec_unit #(.WIDTH(32), .AW(4)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .dst(dst),
        .a(a), .b(b), .busy(busy), .done(done), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .zero(zero), .carry(carry)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  dst;
        logic [31:0] data;
        logic        wen;
        logic        z;
        logic        c;
    } vec_t;

    vec_t vt[15];

    // Issue one single-cycle op; returns at the negedge of its WB cycle.
    task automatic issue(input logic [3:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [3:0] d);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y; dst = d;
        @(negedge clk);
        start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678; dst = 4'hF;
    endtask

    task automatic run_mul(input string nm, input logic [3:0] o,
                           input logic [31:0] x, input logic [31:0] y,
                           input logic [3:0] d, input logic [31:0] exp,
                           input bit inject);
        int busy_cnt = 0;
        int done_at = 0;
        int wr_cnt = 0;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y; dst = d;
        @(negedge clk);
        start = 1'b0; op = 4'd0; a = 32'd1; b = 32'd1; dst = 4'd5;
        for (int c = 1; c <= 40; c++) begin
            if (busy) busy_cnt++;
            if (wr_en) begin
                wr_cnt++;
                if (done_at == 0) begin
                    done_at = c;
                    chk({nm, "_data"}, {32'd0, wr_data}, {32'd0, exp});
                    chk({nm, "_addr"}, {60'd0, wr_addr}, {60'd0, d});
                    chk({nm, "_done"}, {63'd0, done}, 64'd1);
                end
            end
            start = (inject && (c == 5 || c == 20)) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        chk({nm, "_latency"}, 64'(done_at), 64'd33);
        chk({nm, "_busycycles"}, 64'(busy_cnt), 64'd32);
        chk({nm, "_writes"}, 64'(wr_cnt), 64'd1);
    endtask

    initial begin
        int wr_seen;
        vt[0]  = '{4'd0,  32'hFFFFFFFF, 32'd1,       4'd3, 32'h00000000, 1'b1, 1'b1, 1'b1};
        vt[1]  = '{4'd1,  32'd5,        32'd7,       4'd4, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b1};
        vt[2]  = '{4'd6,  32'hFFFFFFFF, 32'd1,       4'd5, 32'h00000001, 1'b1, 1'b0, 1'b0};
        vt[3]  = '{4'd7,  32'hFFFFFFFF, 32'd1,       4'd6, 32'h00000000, 1'b1, 1'b1, 1'b0};
        vt[4]  = '{4'd10, 32'h80000000, 32'd4,       4'd7, 32'hF8000000, 1'b1, 1'b0, 1'b0};
        vt[5]  = '{4'd9,  32'h80000000, 32'd4,       4'd8, 32'h08000000, 1'b1, 1'b0, 1'b0};
        vt[6]  = '{4'd8,  32'h80000000, 32'd36,      4'd9, 32'h00000000, 1'b1, 1'b1, 1'b0};
        vt[7]  = '{4'd2,  32'hF0F0F0F0, 32'hFF00FF00, 4'd1, 32'hF000F000, 1'b1, 1'b0, 1'b0};
        vt[8]  = '{4'd3,  32'hF0F0F0F0, 32'hFF00FF00, 4'd2, 32'hFFF0FFF0, 1'b1, 1'b0, 1'b0};
        vt[9]  = '{4'd4,  32'hF0F0F0F0, 32'hFF00FF00, 4'd10, 32'h0FF00FF0, 1'b1, 1'b0, 1'b0};
        vt[10] = '{4'd5,  32'hF0F0F0F0, 32'hFF00FF00, 4'd11, 32'h000F000F, 1'b1, 1'b0, 1'b0};
        vt[11] = '{4'd0,  32'd7,        32'd8,       4'd0, 32'd15,       1'b1, 1'b0, 1'b0};
        vt[12] = '{4'd1,  32'd7,        32'd7,       4'd12, 32'd0,       1'b1, 1'b1, 1'b0};
        vt[13] = '{4'd13, 32'd9,        32'd9,       4'd13, 32'd0,       1'b0, 1'b1, 1'b0};
        vt[14] = '{4'd15, 32'hFFFFFFFF, 32'd1,       4'd14, 32'd0,       1'b0, 1'b1, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_wr_en", {63'd0, wr_en}, 64'd0);
        chk("rst_wr_addr", {60'd0, wr_addr}, 64'd0);
        chk("rst_wr_data", {32'd0, wr_data}, 64'd0);
        chk("rst_zero_carry", {62'd0, zero, carry}, 64'd0);
        rst = 1'b0;

        foreach (vt[i]) begin
            issue(vt[i].op, vt[i].a, vt[i].b, vt[i].dst);
            chk($sformatf("v%0d_done", i), {63'd0, done}, 64'd1);
            chk($sformatf("v%0d_wr_en", i), {63'd0, wr_en}, {63'd0, vt[i].wen});
            if (vt[i].wen)
                chk($sformatf("v%0d_addr", i), {60'd0, wr_addr}, {60'd0, vt[i].dst});
            chk($sformatf("v%0d_data", i), {32'd0, wr_data}, {32'd0, vt[i].data});
            chk($sformatf("v%0d_zc", i), {62'd0, zero, carry}, {62'd0, vt[i].z, vt[i].c});
            chk($sformatf("v%0d_busy", i), {63'd0, busy}, 64'd0);
            @(negedge clk);
            chk($sformatf("v%0d_done_drop", i), {62'd0, done, wr_en}, 64'd0);
        end

        run_mul("mullo", 4'd11, 32'h00010000, 32'h00010003, 4'd9, 32'h00030000, 1'b0);
        run_mul("mulhu", 4'd12, 32'h00010000, 32'h00010003, 4'd9, 32'h00000001, 1'b0);
        run_mul("mullo_inj", 4'd11, 32'h00010000, 32'h00010003, 4'd9, 32'h00030000, 1'b1);
        run_mul("mullo_big", 4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd2, 32'h00000001, 1'b0);
        run_mul("mulhu_big", 4'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd2, 32'hFFFFFFFE, 1'b0);

        // Back-to-back ADDs
        @(negedge clk);
        start = 1'b1; op = 4'd0; a = 32'd1; b = 32'd2; dst = 4'd1;
        @(negedge clk);
        a = 32'd10; b = 32'd20; dst = 4'd2;
        chk("b2b_first_wen", {63'd0, wr_en}, 64'd1);
        chk("b2b_first", {28'd0, wr_addr, wr_data}, {28'd0, 4'd1, 32'd3});
        @(negedge clk);
        start = 1'b0;
        chk("b2b_second_wen", {63'd0, wr_en}, 64'd1);
        chk("b2b_second", {28'd0, wr_addr, wr_data}, {28'd0, 4'd2, 32'd30});
        @(negedge clk);
        chk("b2b_idle", {62'd0, done, wr_en}, 64'd0);

        // Reset during multiply
        @(negedge clk);
        start = 1'b1; op = 4'd11; a = 32'd3; b = 32'd5; dst = 4'd7;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 10; c++) @(negedge clk);
        chk("abort_busy_before", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_outputs", {61'd0, busy, done, wr_en}, 64'd0);
        wr_seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (wr_en || done || busy) wr_seen++;
            @(negedge clk);
        end
        chk("abort_no_write", 64'(wr_seen), 64'd0);
        issue(4'd0, 32'd100, 32'd23, 4'd6);
        chk("post_abort_add", {29'd0, wr_en, wr_addr, wr_data}, {29'd0, 1'b1, 4'd6, 32'd123});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
